// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch redirect controller.
//   fe_state_e  : front-end sequencer state (run / flush window)
//   bru_res_t   : one lane of branch-resolution results
//   upd_entry_t : one predictor-update queue entry
package fetch_ctrl_pkg;

   localparam int unsigned FE_XLEN = 32;

   typedef enum logic {
      FE_RUN   = 1'b0,
      FE_FLUSH = 1'b1
   } fe_state_e;

   typedef struct packed {
      logic               valid;
      logic               miss;
      logic               taken;
      logic [FE_XLEN-1:0] pc;
      logic [FE_XLEN-1:0] target;
      logic [FE_XLEN-1:0] npc;
   } bru_res_t;

   typedef struct packed {
      logic               taken;
      logic [FE_XLEN-1:0] pc;
      logic [FE_XLEN-1:0] target;
   } upd_entry_t;

   function automatic upd_entry_t bru_to_upd(input bru_res_t r);
      upd_entry_t e;
      e.taken  = r.taken;
      e.pc     = r.pc;
      e.target = r.target;
      return e;
   endfunction

endpackage

// File: rtl/upd_fifo.sv
// Two-write / one-read synchronous FIFO of predictor-update entries.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_wr0_en/i_wr0_data   : older write (lands first)
//   i_wr1_en/i_wr1_data   : younger write
//   o_ready               : at least two free entries (from registered count)
//   o_valid/o_head        : queue non-empty / head entry; head pops every valid cycle
module upd_fifo
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned UPD_QDEPTH = 4
)
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_wr0_en,
   input  upd_entry_t i_wr0_data,
   input  logic       i_wr1_en,
   input  upd_entry_t i_wr1_data,
   output logic       o_ready,
   output logic       o_valid,
   output upd_entry_t o_head
);

   localparam int unsigned AW        = $clog2(UPD_QDEPTH);
   localparam logic [AW:0] ONE       = (AW+1)'(1);
   localparam logic [AW:0] TWO       = (AW+1)'(2);
   localparam logic [AW:0] READY_MAX = (AW+1)'(UPD_QDEPTH - 2);
   localparam logic [AW:0] DEPTH_C   = (AW+1)'(UPD_QDEPTH);

   upd_entry_t  mem_q [UPD_QDEPTH];
   logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, cnt_q, cnt_d;
   logic [AW:0] wptr_b;
   logic        push_a, push_b, pop;
   upd_entry_t  data_a;

   // Writes are compacted: a lone lane-1 write still lands in the first free slot.
   assign push_a = i_wr0_en | i_wr1_en;
   assign push_b = i_wr0_en & i_wr1_en;
   assign data_a = i_wr0_en ? i_wr0_data : i_wr1_data;
   assign wptr_b = wptr_q + ONE;
   assign pop    = (cnt_q != '0);

   assign o_ready = (cnt_q <= READY_MAX);
   assign o_valid = pop;
   assign o_head  = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      if (push_b)      wptr_d = wptr_q + TWO;
      else if (push_a) wptr_d = wptr_q + ONE;
      rptr_d = pop ? (rptr_q + ONE) : rptr_q;
      cnt_d  = cnt_q + {{AW{1'b0}}, push_a} + {{AW{1'b0}}, push_b} - {{AW{1'b0}}, pop};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage carries no reset; pointers alone define which slots are live.
   always_ff @(posedge i_clk) begin
      if (push_a) mem_q[wptr_q[AW-1:0]] <= data_a;
      if (push_b) mem_q[wptr_b[AW-1:0]] <= i_wr1_data;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         a_cnt_bound: assert (cnt_q <= DEPTH_C)
            else $error("update queue count exceeds depth");
      end
   end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Front-end sequencer for the 2-issue fetch path.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_dec_stall             : decode backpressure, holds PC
//   i_trap_*                : trap redirect request and vector
//   i_bru{0,1}_*            : per-lane branch resolution (lane 0 older)
//   o_bru_ready             : update queue can accept two entries
//   o_pc_en                 : PC register enable
//   o_redirect_valid/target : load target into PC this cycle
//   o_flush                 : squash fetch/decode
//   o_upd_*                 : predictor update strobe and head-of-queue payload
module fetch_redirect_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned UPD_QDEPTH   = 4
)
(
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_dec_stall,
   input  logic            i_trap_valid,
   input  logic [XLEN-1:0] i_trap_target,
   input  logic            i_bru0_valid,
   input  logic            i_bru0_miss,
   input  logic            i_bru0_taken,
   input  logic [XLEN-1:0] i_bru0_pc,
   input  logic [XLEN-1:0] i_bru0_target,
   input  logic [XLEN-1:0] i_bru0_npc,
   input  logic            i_bru1_valid,
   input  logic            i_bru1_miss,
   input  logic            i_bru1_taken,
   input  logic [XLEN-1:0] i_bru1_pc,
   input  logic [XLEN-1:0] i_bru1_target,
   input  logic [XLEN-1:0] i_bru1_npc,
   output logic            o_bru_ready,
   output logic            o_pc_en,
   output logic            o_redirect_valid,
   output logic [XLEN-1:0] o_redirect_target,
   output logic            o_flush,
   output logic            o_upd_en,
   output logic            o_upd_taken,
   output logic [XLEN-1:0] o_upd_pc,
   output logic [XLEN-1:0] o_upd_target
);

   localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

   bru_res_t        bru0, bru1;
   fe_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic            lane0_miss, lane1_miss, redirect;
   logic [XLEN-1:0] redir_tgt;
   logic            q_ready, q_valid, wr0, wr1;
   upd_entry_t      q_head;

   assign bru0 = '{valid: i_bru0_valid, miss: i_bru0_miss, taken: i_bru0_taken,
                   pc: i_bru0_pc, target: i_bru0_target, npc: i_bru0_npc};
   assign bru1 = '{valid: i_bru1_valid, miss: i_bru1_miss, taken: i_bru1_taken,
                   pc: i_bru1_pc, target: i_bru1_target, npc: i_bru1_npc};

   // A lane-0 mispredict makes the lane-1 result wrong-path: no redirect, no update.
   assign lane0_miss = bru0.valid & bru0.miss;
   assign lane1_miss = bru1.valid & bru1.miss & ~lane0_miss;
   assign redirect   = i_trap_valid | lane0_miss | lane1_miss;

   always_comb begin
      redir_tgt = '0;
      if (i_trap_valid)    redir_tgt = i_trap_target;
      else if (lane0_miss) redir_tgt = bru0.npc;
      else if (lane1_miss) redir_tgt = bru1.npc;
   end

   // Redirect acts in the same cycle; reset forces every output low.
   assign o_redirect_valid  = ~i_rst & redirect;
   assign o_redirect_target = i_rst ? '0 : redir_tgt;
   assign o_flush           = ~i_rst & (redirect | (state_q == FE_FLUSH));
   assign o_pc_en           = ~i_rst & (redirect | ((state_q == FE_RUN) & ~i_dec_stall));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= FE_RUN;
         cnt_q   <= '0;
      end else if (redirect) begin
         state_q <= FE_FLUSH;
         cnt_q   <= CNT_W'(FLUSH_CYCLES);
      end else if (state_q == FE_FLUSH) begin
         if (cnt_q == CNT_W'(1)) begin
            state_q <= FE_RUN;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

   // Trap does not suppress enqueues; results offered without ready are dropped.
   assign o_bru_ready = ~i_rst & q_ready;
   assign wr0 = o_bru_ready & bru0.valid;
   assign wr1 = o_bru_ready & bru1.valid & ~lane0_miss;

   upd_fifo #(.UPD_QDEPTH(UPD_QDEPTH)) u_upd_fifo (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_wr0_en   (wr0),
      .i_wr0_data (bru_to_upd(bru0)),
      .i_wr1_en   (wr1),
      .i_wr1_data (bru_to_upd(bru1)),
      .o_ready    (q_ready),
      .o_valid    (q_valid),
      .o_head     (q_head)
   );

   assign o_upd_en     = ~i_rst & q_valid;
   assign o_upd_taken  = o_upd_en & q_head.taken;
   assign o_upd_pc     = o_upd_en ? q_head.pc : '0;
   assign o_upd_target = o_upd_en ? q_head.target : '0;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         a_bru_proto: assert (!((i_bru0_valid || i_bru1_valid) && !o_bru_ready))
            else $error("branch result offered while o_bru_ready low; dropped");
      end
   end

endmodule
